// File: rtl/tt_mpu_pkg.sv
// -----------------------------------------------------------------------------
// tt_mpu_pkg
// Shared types for the MPU outer-product accumulate engine.
//   mpu_op_e    : command opcodes carried on i_cmd_op
//   mpu_state_e : engine FSM states
//   idxWidth()  : index width for a table of N entries, never below one bit
// Optional feature macro used by the engine: TT_MPU_SATURATE_EN
// -----------------------------------------------------------------------------
package tt_mpu_pkg;

  typedef enum logic [1:0] {
    OP_WR_ROW = 2'd0,
    OP_OPACC  = 2'd1,
    OP_RD_ROW = 2'd2,
    OP_ZERO   = 2'd3
  } mpu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OPACC = 1'b1
  } mpu_state_e;

  // A one-entry table still needs a one-bit index so port widths stay legal.
  function automatic int idxWidth(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/tt_mpu_mac_row.sv
// -----------------------------------------------------------------------------
// tt_mpu_mac_row
// Combinational update of one accumulator row: c_row_o[i] = c_row_i[i] + a_i*b_i[i]
// for every XLEN-bit lane i.
//   c_row_i : current accumulator row (VLEN bits, VLEN/XLEN lanes)
//   a_i     : single A element broadcast to all lanes
//   b_i     : B vector, one element per lane
//   c_row_o : updated row
// Macro TT_MPU_SATURATE_EN: signed lanes, product and sum both saturate.
// Default build: unsigned lanes, product and sum wrap modulo 2^XLEN.
// -----------------------------------------------------------------------------
module tt_mpu_mac_row #(
  parameter int VLEN = 256,
  parameter int XLEN = 64
) (
  input  logic [VLEN-1:0] c_row_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [VLEN-1:0] b_i,
  output logic [VLEN-1:0] c_row_o
);

  localparam int VL = VLEN / XLEN;

  for (genvar i = 0; i < VL; i++) begin : g_lane
    logic [XLEN-1:0] bLane;
    logic [XLEN-1:0] cLane;
    logic [XLEN-1:0] sumLane;

    assign bLane = b_i[i*XLEN +: XLEN];
    assign cLane = c_row_i[i*XLEN +: XLEN];

`ifdef TT_MPU_SATURATE_EN
    localparam logic [XLEN-1:0] SatMax = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic [XLEN-1:0] SatMin = {1'b1, {(XLEN-1){1'b0}}};

    logic signed [2*XLEN-1:0] prodFull;
    logic        [XLEN-1:0]   prodSat;
    logic        [XLEN:0]     sumFull;

    // Full-width signed product; it fits in XLEN bits only when the top XLEN+1
    // bits are all copies of the sign bit.
    assign prodFull = $signed(a_i) * $signed(bLane);

    always_comb begin
      prodSat = prodFull[XLEN-1:0];
      if (prodFull[2*XLEN-1:XLEN-1] != {(XLEN+1){prodFull[2*XLEN-1]}}) begin
        prodSat = prodFull[2*XLEN-1] ? SatMin : SatMax;
      end
    end

    // One guard bit: overflow shows up as the guard and sign bits disagreeing,
    // and the guard bit then holds the true sign of the result.
    assign sumFull = {cLane[XLEN-1], cLane} + {prodSat[XLEN-1], prodSat};

    always_comb begin
      sumLane = sumFull[XLEN-1:0];
      if (sumFull[XLEN] != sumFull[XLEN-1]) begin
        sumLane = sumFull[XLEN] ? SatMin : SatMax;
      end
    end
`else
    // Lane width of the target truncates both product and sum.
    assign sumLane = cLane + a_i * bLane;
`endif

    assign c_row_o[i*XLEN +: XLEN] = sumLane;
  end

endmodule

// File: rtl/tt_mpu_opacc_engine.sv
// -----------------------------------------------------------------------------
// tt_mpu_opacc_engine
// Matrix accumulator bank with an outer-product accumulate engine.
// NUM_MREGS accumulator registers, each ML rows of VLEN bits.
//   i_clk, i_reset_n            : clock, synchronous active-low reset
//   i_cmd_vld/o_cmd_rdy         : command handshake
//   i_cmd_op/mreg/row/lq_id     : opcode, target mreg, target row, read tag
//   i_a_data, i_b_data          : OPACC operands (A: ML elements, B: VL elements)
//   i_wr_data                   : WR_ROW data
//   o_lq_vld/i_lq_rdy           : load-queue response handshake
//   o_lq_data, o_lq_id          : RD_ROW response data and tag
//   o_busy                      : high while an OPACC is running
// Macro TT_MPU_SATURATE_EN selects signed saturating accumulation.
// -----------------------------------------------------------------------------
module tt_mpu_opacc_engine
  import tt_mpu_pkg::*;
#(
  parameter  int VLEN          = 256,
  parameter  int MLEN          = 256,
  parameter  int XLEN          = 64,
  parameter  int NUM_MREGS     = 4,
  parameter  int LQ_DEPTH_LOG2 = 3,
  localparam int VL            = VLEN / XLEN,
  localparam int ML            = MLEN / XLEN,
  localparam int MW            = idxWidth(NUM_MREGS),
  localparam int RW            = idxWidth(ML)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_cmd_vld,
  output logic                     o_cmd_rdy,
  input  logic [1:0]               i_cmd_op,
  input  logic [MW-1:0]            i_cmd_mreg,
  input  logic [RW-1:0]            i_cmd_row,
  input  logic [LQ_DEPTH_LOG2-1:0] i_cmd_lq_id,
  input  logic [MLEN-1:0]          i_a_data,
  input  logic [VLEN-1:0]          i_b_data,
  input  logic [VLEN-1:0]          i_wr_data,
  output logic                     o_lq_vld,
  input  logic                     i_lq_rdy,
  output logic [VLEN-1:0]          o_lq_data,
  output logic [LQ_DEPTH_LOG2-1:0] o_lq_id,
  output logic                     o_busy
);

  mpu_state_e             state_q, state_d;
  logic [RW-1:0]          rowCnt_q, rowCnt_d;
  logic [VLEN-1:0]        cMem_q [NUM_MREGS][ML];
  logic [MLEN-1:0]        accA_q;
  logic [VLEN-1:0]        accB_q;
  logic [MW-1:0]          accMreg_q;
  logic                   lqVld_q;
  logic [VLEN-1:0]        lqData_q;
  logic [LQ_DEPTH_LOG2-1:0] lqId_q;

  mpu_op_e         cmdOp;
  logic            cmdAccept;
  logic            accEn;
  logic            lastRow;
  logic [XLEN-1:0] aElem;
  logic [VLEN-1:0] accRowIn;
  logic [VLEN-1:0] accRowOut;

  assign cmdOp     = mpu_op_e'(i_cmd_op);
  assign cmdAccept = i_cmd_vld & o_cmd_rdy;
  assign lastRow   = (rowCnt_q == RW'(ML - 1));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: an accepted OPACC runs one row per cycle until the last row
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmdAccept && cmdOp == OP_OPACC) state_d = OPACC;
      OPACC:   if (lastRow) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a stalled load-queue response also blocks new commands so a
  // pending read is never overwritten
  always_comb begin
    o_cmd_rdy = 1'b0;
    o_busy    = 1'b0;
    accEn     = 1'b0;
    case (state_q)
      IDLE:    o_cmd_rdy = ~(lqVld_q & ~i_lq_rdy);
      OPACC: begin
        o_busy = 1'b1;
        accEn  = 1'b1;
      end
      default: ;
    endcase
  end

  // Row counter walks 0..ML-1 during OPACC and restarts on each new OPACC
  always_comb begin
    rowCnt_d = rowCnt_q;
    if (cmdAccept && cmdOp == OP_OPACC) rowCnt_d = '0;
    else if (accEn)                     rowCnt_d = lastRow ? '0 : rowCnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) rowCnt_q <= '0;
    else            rowCnt_q <= rowCnt_d;
  end

  // OPACC operands are captured once so the command bus is free afterwards
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      accA_q    <= '0;
      accB_q    <= '0;
      accMreg_q <= '0;
    end else if (cmdAccept && cmdOp == OP_OPACC) begin
      accA_q    <= i_a_data;
      accB_q    <= i_b_data;
      accMreg_q <= i_cmd_mreg;
    end
  end

  assign aElem    = accA_q[int'(rowCnt_q)*XLEN +: XLEN];
  assign accRowIn = cMem_q[accMreg_q][rowCnt_q];

  tt_mpu_mac_row #(
    .VLEN (VLEN),
    .XLEN (XLEN)
  ) u_macRow (
    .c_row_i (accRowIn),
    .a_i     (aElem),
    .b_i     (accB_q),
    .c_row_o (accRowOut)
  );

  // Accumulator storage; commands and OPACC never overlap, so at most one
  // writer is active on any edge
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int m = 0; m < NUM_MREGS; m++) begin
        for (int r = 0; r < ML; r++) begin
          cMem_q[m][r] <= '0;
        end
      end
    end else if (cmdAccept && cmdOp == OP_WR_ROW) begin
      cMem_q[i_cmd_mreg][i_cmd_row] <= i_wr_data;
    end else if (cmdAccept && cmdOp == OP_ZERO) begin
      for (int r = 0; r < ML; r++) begin
        cMem_q[i_cmd_mreg][r] <= '0;
      end
    end else if (accEn) begin
      cMem_q[accMreg_q][rowCnt_q] <= accRowOut;
    end
  end

  // Load-queue response holds until consumed; a read accepted on the consuming
  // edge replaces it directly so back-to-back reads need no bubble
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lqVld_q  <= 1'b0;
      lqData_q <= '0;
      lqId_q   <= '0;
    end else if (cmdAccept && cmdOp == OP_RD_ROW) begin
      lqVld_q  <= 1'b1;
      lqData_q <= cMem_q[i_cmd_mreg][i_cmd_row];
      lqId_q   <= i_cmd_lq_id;
    end else if (lqVld_q && i_lq_rdy) begin
      lqVld_q  <= 1'b0;
    end
  end

  assign o_lq_vld  = lqVld_q;
  assign o_lq_data = lqData_q;
  assign o_lq_id   = lqId_q;

endmodule

// File: tb/tb_tt_mpu_opacc_engine.sv
// -----------------------------------------------------------------------------
// tb_tt_mpu_opacc_engine
// Self-checking bench for tt_mpu_opacc_engine at XLEN=64, VL=ML=4, 4 mregs.
// Honours TT_MPU_SATURATE_EN in its reference model and corner cases.
// -----------------------------------------------------------------------------
module tb_tt_mpu_opacc_engine;
  import tt_mpu_pkg::*;

  localparam int VLEN = 256;
  localparam int MLEN = 256;
  localparam int XLEN = 64;
  localparam int NUM_MREGS = 4;
  localparam int LQW = 3;
  localparam int VL = 4;
  localparam int ML = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_cmd_vld;
  logic             o_cmd_rdy;
  logic [1:0]       i_cmd_op;
  logic [1:0]       i_cmd_mreg;
  logic [1:0]       i_cmd_row;
  logic [LQW-1:0]   i_cmd_lq_id;
  logic [MLEN-1:0]  i_a_data;
  logic [VLEN-1:0]  i_b_data;
  logic [VLEN-1:0]  i_wr_data;
  logic             o_lq_vld;
  logic             i_lq_rdy;
  logic [VLEN-1:0]  o_lq_data;
  logic [LQW-1:0]   o_lq_id;
  logic             o_busy;

  int vecCount  = 0;
  int missCount = 0;

  // Reference accumulator contents, one 64-bit element per lane
  longint unsigned cm [NUM_MREGS][ML][VL];

  typedef struct {
    mpu_op_e          op;
    int               mreg;
    int               row;
    int               id;
    logic [VLEN-1:0]  data;
    logic [VLEN-1:0]  expData;
  } vec_t;

  vec_t vecs[8];

  always #5 i_clk = ~i_clk;

  tt_mpu_opacc_engine #(
    .VLEN (VLEN), .MLEN (MLEN), .XLEN (XLEN),
    .NUM_MREGS (NUM_MREGS), .LQ_DEPTH_LOG2 (LQW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_cmd_vld   (i_cmd_vld),
    .o_cmd_rdy   (o_cmd_rdy),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_mreg  (i_cmd_mreg),
    .i_cmd_row   (i_cmd_row),
    .i_cmd_lq_id (i_cmd_lq_id),
    .i_a_data    (i_a_data),
    .i_b_data    (i_b_data),
    .i_wr_data   (i_wr_data),
    .o_lq_vld    (o_lq_vld),
    .i_lq_rdy    (i_lq_rdy),
    .o_lq_data   (o_lq_data),
    .o_lq_id     (o_lq_id),
    .o_busy      (o_busy)
  );

  // Element 0 sits in the least significant lane
  function automatic logic [VLEN-1:0] pack4(input longint unsigned e0, input longint unsigned e1,
                                            input longint unsigned e2, input longint unsigned e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [VLEN-1:0] randVec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // c + a*b as plain arithmetic: unsigned wrap, or signed clamp when saturating
  function automatic longint unsigned macModel(input longint unsigned c, input longint unsigned a,
                                               input longint unsigned b);
`ifdef TT_MPU_SATURATE_EN
    logic signed [127:0] smax = 128'sh7FFF_FFFF_FFFF_FFFF;
    logic signed [127:0] smin;
    logic signed [127:0] p;
    logic signed [127:0] s;
    longint sa, sb, sc;
    smin = -smax - 128'sd1;
    sa = a; sb = b; sc = c;
    p = 128'(sa) * 128'(sb);
    if (p > smax) p = smax;
    else if (p < smin) p = smin;
    s = 128'(sc) + p;
    if (s > smax) s = smax;
    else if (s < smin) s = smin;
    return longint'(s[63:0]);
`else
    return c + a * b;
`endif
  endfunction

  function automatic logic [VLEN-1:0] modelRow(input int m, input int r);
    logic [VLEN-1:0] v;
    for (int i = 0; i < VL; i++) v[i*XLEN +: XLEN] = cm[m][r][i];
    return v;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < NUM_MREGS; m++)
      for (int r = 0; r < ML; r++)
        for (int i = 0; i < VL; i++) cm[m][r][i] = 0;
  endtask

  task automatic modelApply(input mpu_op_e op, input int m, input int r, input logic [VLEN-1:0] wr,
                            input logic [MLEN-1:0] a, input logic [VLEN-1:0] b);
    case (op)
      OP_WR_ROW: for (int i = 0; i < VL; i++) cm[m][r][i] = wr[i*XLEN +: XLEN];
      OP_ZERO:   for (int k = 0; k < ML; k++) for (int i = 0; i < VL; i++) cm[m][k][i] = 0;
      OP_OPACC:  for (int k = 0; k < ML; k++)
                   for (int i = 0; i < VL; i++)
                     cm[m][k][i] = macModel(cm[m][k][i], a[k*XLEN +: XLEN], b[i*XLEN +: XLEN]);
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits (bounded) for o_cmd_rdy, presents one command for one accepting edge
  task automatic applyStimulus(input mpu_op_e op, input int m, input int r, input int id,
                               input logic [VLEN-1:0] wr, input logic [MLEN-1:0] a,
                               input logic [VLEN-1:0] b);
    int waitCnt = 0;
    while (!o_cmd_rdy && waitCnt < 50) begin
      @(posedge i_clk); #1;
      waitCnt++;
    end
    checkOutput("cmd_rdy_wait", VLEN'(o_cmd_rdy), VLEN'(1));
    i_cmd_vld   = 1'b1;
    i_cmd_op    = op;
    i_cmd_mreg  = 2'(m);
    i_cmd_row   = 2'(r);
    i_cmd_lq_id = LQW'(id);
    i_wr_data   = wr;
    i_a_data    = a;
    i_b_data    = b;
    @(posedge i_clk); #1;
    i_cmd_vld = 1'b0;
    modelApply(op, m, r, wr, a, b);
  endtask

  // Counts sampled cycles with o_cmd_rdy low, bounded
  task automatic waitIdle(output int lowCycles);
    lowCycles = 0;
    while (!o_cmd_rdy && lowCycles < 50) begin
      @(posedge i_clk); #1;
      lowCycles++;
    end
  endtask

  task automatic doRead(input string name, input int m, input int r, input int id,
                        input logic [VLEN-1:0] exp);
    applyStimulus(OP_RD_ROW, m, r, id, '0, '0, '0);
    checkOutput({name, "_vld"}, VLEN'(o_lq_vld), VLEN'(1));
    checkOutput({name, "_data"}, o_lq_data, exp);
    checkOutput({name, "_id"}, VLEN'(o_lq_id), VLEN'(id));
  endtask

  task automatic doOpacc(input string name, input int m, input logic [MLEN-1:0] a,
                         input logic [VLEN-1:0] b);
    int lowCycles;
    applyStimulus(OP_OPACC, m, 0, 0, '0, a, b);
    waitIdle(lowCycles);
    checkOutput({name, "_len"}, VLEN'(lowCycles), VLEN'(ML));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lowCycles;
    logic [VLEN-1:0] junk;

    i_reset_n = 1'b0; i_cmd_vld = 1'b0; i_cmd_op = '0; i_cmd_mreg = '0; i_cmd_row = '0;
    i_cmd_lq_id = '0; i_a_data = '0; i_b_data = '0; i_wr_data = '0; i_lq_rdy = 1'b1;
    modelReset();

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_rdy", VLEN'(o_cmd_rdy), VLEN'(1));
    checkOutput("rst_busy", VLEN'(o_busy), VLEN'(0));
    checkOutput("rst_lq_vld", VLEN'(o_lq_vld), VLEN'(0));
    checkOutput("rst_lq_data", o_lq_data, '0);
    checkOutput("rst_lq_id", VLEN'(o_lq_id), VLEN'(0));
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // Table of basic write/zero/read vectors
    vecs[0] = '{OP_WR_ROW, 1, 2, 0, pack4(1, 2, 3, 4), '0};
    vecs[1] = '{OP_RD_ROW, 1, 2, 5, '0, pack4(1, 2, 3, 4)};
    vecs[2] = '{OP_WR_ROW, 3, 0, 0, pack4(64'hDEAD, 64'hBEEF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF), '0};
    vecs[3] = '{OP_RD_ROW, 3, 0, 2, '0, pack4(64'hDEAD, 64'hBEEF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF)};
    vecs[4] = '{OP_ZERO,   1, 0, 0, '0, '0};
    vecs[5] = '{OP_RD_ROW, 1, 2, 7, '0, '0};
    vecs[6] = '{OP_RD_ROW, 3, 0, 1, '0, pack4(64'hDEAD, 64'hBEEF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF)};
    vecs[7] = '{OP_RD_ROW, 0, 3, 3, '0, '0};
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].op == OP_RD_ROW)
        doRead($sformatf("vec%0d", v), vecs[v].mreg, vecs[v].row, vecs[v].id, vecs[v].expData);
      else
        applyStimulus(vecs[v].op, vecs[v].mreg, vecs[v].row, vecs[v].id, vecs[v].data, '0, '0);
    end

    // Single outer product into a cleared mreg
    applyStimulus(OP_ZERO, 0, 0, 0, '0, '0, '0);
    doOpacc("opacc1", 0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40));
    doRead("opacc1_r3", 0, 3, 4, pack4(40, 80, 120, 160));

    // Second accumulation with a command held on the bus the whole time
    applyStimulus(OP_OPACC, 0, 0, 0, '0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40));
    junk = {VLEN{1'b1}};
    i_cmd_vld = 1'b1; i_cmd_op = OP_WR_ROW; i_cmd_mreg = 2'd0; i_cmd_row = 2'd0; i_wr_data = junk;
    waitIdle(lowCycles);
    i_cmd_vld = 1'b0;
    checkOutput("opacc2_len", VLEN'(lowCycles), VLEN'(ML));
    doRead("opacc2_r0", 0, 0, 0, pack4(20, 40, 60, 80));
    doRead("opacc2_r3", 0, 3, 6, modelRow(0, 3));

    // Load-queue backpressure holds the response and blocks commands
    @(posedge i_clk); #1;
    i_lq_rdy = 1'b0;
    doRead("bp", 0, 1, 6, pack4(40, 80, 120, 160));
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      checkOutput($sformatf("bp_hold%0d_vld", c), VLEN'(o_lq_vld), VLEN'(1));
      checkOutput($sformatf("bp_hold%0d_data", c), o_lq_data, pack4(40, 80, 120, 160));
      checkOutput($sformatf("bp_hold%0d_id", c), VLEN'(o_lq_id), VLEN'(6));
      checkOutput($sformatf("bp_hold%0d_rdy", c), VLEN'(o_cmd_rdy), VLEN'(0));
    end
    i_lq_rdy = 1'b1;
    #1;
    checkOutput("bp_release_rdy", VLEN'(o_cmd_rdy), VLEN'(1));
    @(posedge i_clk); #1;
    checkOutput("bp_release_vld", VLEN'(o_lq_vld), VLEN'(0));

    // Wrap-around or saturation at the numeric boundary
`ifdef TT_MPU_SATURATE_EN
    applyStimulus(OP_WR_ROW, 3, 0, 0, pack4(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF), '0, '0);
    doOpacc("bound", 3, pack4(1, 0, 0, 0), pack4(1, 1, 1, 1));
    doRead("bound_r0", 3, 0, 2, pack4(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF));
`else
    applyStimulus(OP_WR_ROW, 3, 0, 0, {VLEN{1'b1}}, '0, '0);
    doOpacc("bound", 3, pack4(1, 0, 0, 0), pack4(1, 1, 1, 1));
    doRead("bound_r0", 3, 0, 2, '0);
`endif

    // Reset during cycle 2 of an OPACC
    applyStimulus(OP_WR_ROW, 2, 1, 0, pack4(5, 6, 7, 8), '0, '0);
    applyStimulus(OP_OPACC, 0, 0, 0, '0, pack4(1, 1, 1, 1), pack4(3, 3, 3, 3));
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("midrst_busy", VLEN'(o_busy), VLEN'(0));
    checkOutput("midrst_lq_vld", VLEN'(o_lq_vld), VLEN'(0));
    i_reset_n = 1'b1;
    modelReset();
    @(posedge i_clk); #1;
    checkOutput("midrst_rdy", VLEN'(o_cmd_rdy), VLEN'(1));
    for (int r = 0; r < ML; r++) doRead($sformatf("midrst_m0r%0d", r), 0, r, r, '0);
    doRead("midrst_m2r1", 2, 1, 1, '0);

    // Randomized commands against the reference model
    for (int n = 0; n < 120; n++) begin
      mpu_op_e op;
      int m, r, id;
      op = mpu_op_e'($urandom_range(0, 3));
      m  = $urandom_range(0, NUM_MREGS - 1);
      r  = $urandom_range(0, ML - 1);
      id = $urandom_range(0, 7);
      case (op)
        OP_RD_ROW: doRead($sformatf("rnd%0d", n), m, r, id, modelRow(m, r));
        OP_OPACC:  doOpacc($sformatf("rnd%0d", n), m, randVec(), randVec());
        default:   applyStimulus(op, m, r, id, randVec(), '0, '0);
      endcase
    end
    for (int m = 0; m < NUM_MREGS; m++)
      for (int r = 0; r < ML; r++)
        doRead($sformatf("final_m%0dr%0d", m, r), m, r, r, modelRow(m, r));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/tt_mpu_opacc_engine.md
TT_MPU_OPACC_ENGINE -- requirements
Module: tt_mpu_opacc_engine

Interface
REQ-001 SHALL have parameter VLEN, default 256, B-vector/C-row width in bits.
REQ-002 SHALL have parameter MLEN, default 256, A-vector width in bits.
REQ-003 SHALL have parameter XLEN, default 64, element width; derived VL=VLEN/XLEN, ML=MLEN/XLEN, ML rows per mreg.
REQ-004 SHALL have parameter NUM_MREGS, default 4, power of two; MW=$clog2(NUM_MREGS), RW=$clog2(ML).
REQ-005 SHALL have parameter LQ_DEPTH_LOG2, default 3, load-queue tag width.
REQ-006 SHALL have ports: i_clk in 1 clock; i_reset_n in 1, reset, synchronous, active-low.
REQ-007 SHALL have ports: i_cmd_vld in 1; o_cmd_rdy out 1; i_cmd_op in 2 (0 WR_ROW, 1 OPACC, 2 RD_ROW, 3 ZERO); i_cmd_mreg in MW; i_cmd_row in RW; i_cmd_lq_id in LQ_DEPTH_LOG2.
REQ-008 SHALL have ports: i_a_data in MLEN; i_b_data in VLEN; i_wr_data in VLEN.
REQ-009 SHALL have ports: o_lq_vld out 1; i_lq_rdy in 1; o_lq_data out VLEN; o_lq_id out LQ_DEPTH_LOG2; o_busy out 1 (FSM not IDLE).

Function
REQ-010 SHALL accept a command on a rising edge where i_cmd_vld & o_cmd_rdy.
REQ-011 SHALL drive o_cmd_rdy = (state==IDLE) & ~(o_lq_vld & ~i_lq_rdy).
REQ-012 WR_ROW SHALL write i_wr_data into C[mreg][row] on the accept edge.
REQ-013 ZERO SHALL clear all ML rows of C[mreg] on the accept edge.
REQ-014 RD_ROW SHALL load o_lq_data=C[mreg][row], o_lq_id=i_cmd_lq_id and set o_lq_vld on the accept edge; visible next cycle.
REQ-015 o_lq_vld/data/id SHALL hold stable until o_lq_vld & i_lq_rdy; o_lq_vld clears on that edge unless a new RD_ROW is accepted the same edge (back-to-back reads allowed when i_lq_rdy=1).
REQ-016 OPACC SHALL latch A, B, mreg on accept and enter state OPACC with row counter 0.
REQ-017 In OPACC, each cycle k (0..ML-1) SHALL update C[mreg][k][i] += A[k]*B[i] for all i<VL, one row per edge.
REQ-018 FSM SHALL return to IDLE on the edge writing row ML-1; OPACC occupies exactly ML cycles, o_cmd_rdy low throughout.
REQ-019 Products and sums SHALL be unsigned XLEN-bit, truncated modulo 2^XLEN (wrap-around) unless REQ-025 applies.
REQ-020 OPACC SHALL produce no load-queue response.
REQ-021 Commands SHALL NOT be accepted during OPACC; in-flight result visible to the first RD_ROW accepted after.

Reset
REQ-022 On i_reset_n=0 at a rising edge: state=IDLE, row counter=0, all C rows=0, o_lq_vld=0, o_lq_data=0, o_lq_id=0.
REQ-023 Reset mid-OPACC SHALL abort; partially updated rows SHALL also be cleared; o_cmd_rdy=1 the cycle after reset deasserts.
REQ-024 Outputs after reset: o_cmd_rdy=1, o_busy=0, o_lq_vld=0.

Configuration
REQ-025 Macro TT_MPU_SATURATE_EN defined: A, B, C signed two's-complement; each accumulate saturates to [-2^(XLEN-1), 2^(XLEN-1)-1], product computed at 2*XLEN then saturated before add. Undefined: REQ-019 wrap-around.

Structure
REQ-026 Package tt_mpu_pkg SHALL hold the op enum (WR_ROW/OPACC/RD_ROW/ZERO) and FSM state enum (IDLE/OPACC).
REQ-027 Sub-module tt_mpu_mac_row SHALL compute one VL-lane row update (C_row + a*B), honouring TT_MPU_SATURATE_EN.

Verification (XLEN=64, VL=ML=4, NUM_MREGS=4)
REQ-028 WR_ROW mreg1 row2 data {4,3,2,1}, then RD_ROW id5 -> o_lq_vld next cycle, data {4,3,2,1}, id 5.
REQ-029 ZERO mreg0; OPACC A={1,2,3,4}, B={10,20,30,40} -> o_cmd_rdy low 4 cycles; RD_ROW row3 -> {160,120,80,40}.
REQ-030 OPACC twice same A,B -> row0 reads {80,60,40,20}; i_cmd_vld held during OPACC not accepted.
REQ-031 RD_ROW with i_lq_rdy=0 for 3 cycles -> data/id stable, o_cmd_rdy=0; release -> o_lq_vld drops next edge.
REQ-032 Reset asserted at OPACC cycle 2 -> all rows 0, o_busy=0, o_lq_vld=0.
REQ-033 C=2^64-1, A=1, B=1: default -> 0; TT_MPU_SATURATE_EN with C=2^63-1 -> stays 2^63-1.
